// File: rtl/rv32i_dbus_bridge.sv
// rv32i_dbus_bridge
//   Sits between the core's data port and a pipelined memory-mapped bus.
//   Stores are posted into a small write buffer and never stall the core;
//   loads stall the core (dwaitrequest) until the bus returns data, and are
//   only issued once every earlier buffered store has been accepted.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   daddress/dwrite/dwritedata/dbyteenable/dread   core request side
//   dreaddata/dwaitrequest                         core response side
//   avm_*                 pipelined bus master (waitrequest + readdatavalid)
//   wbuf_level            entries currently held in the write buffer
//   wbuf_overflow         sticky: a store was dropped because the buffer was full
module rv32i_dbus_bridge #(
  parameter int WBUF_LOG2_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [31:0]              daddress,
  input  logic                     dwrite,
  input  logic [31:0]              dwritedata,
  input  logic [3:0]               dbyteenable,
  input  logic                     dread,
  output logic [31:0]              dreaddata,
  output logic                     dwaitrequest,
  output logic [31:0]              avm_address,
  output logic                     avm_write,
  output logic [31:0]              avm_writedata,
  output logic [3:0]               avm_byteenable,
  output logic                     avm_read,
  input  logic [31:0]              avm_readdata,
  input  logic                     avm_readdatavalid,
  input  logic                     avm_waitrequest,
  output logic [WBUF_LOG2_DEPTH:0] wbuf_level,
  output logic                     wbuf_overflow
);
  localparam int DEPTH = 1 << WBUF_LOG2_DEPTH;
  localparam int LW    = WBUF_LOG2_DEPTH + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wbuf_ent_t;

  typedef enum logic [2:0] {IDLE, DRAIN, RD_REQ, RD_WAIT, RD_DONE} state_t;

  wbuf_ent_t                  wbuf [DEPTH];
  wbuf_ent_t                  head;
  logic [WBUF_LOG2_DEPTH-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0]              level, level_nxt;
  logic                       fifo_empty, fifo_full, push, pop, wr_issue;
  state_t                     state, state_nxt;

  // ---------------------------------------------------------------- write buffer
  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == FULL_LVL);
  // Full is judged on the current level: a store arriving in the same cycle
  // as the pop that would free a slot is still dropped.
  assign push       = dwrite & ~fifo_full;
  // Buffered stores drain only while no load owns the bus.
  assign wr_issue   = ~fifo_empty & ((state == IDLE) | (state == DRAIN));
  assign pop        = wr_issue & ~avm_waitrequest;
  assign head       = wbuf[rd_ptr];
  assign wbuf_level = level;

  always_comb begin
    level_nxt = level;
    unique case ({push, pop})
      2'b10:   level_nxt = level + 1'b1;
      2'b01:   level_nxt = level - 1'b1;
      default: level_nxt = level;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level         <= '0;
      wbuf_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level_nxt;
      if (dwrite & fifo_full) wbuf_overflow <= 1'b1;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and level.
  always_ff @(posedge clk) begin
    if (push) wbuf[wr_ptr] <= '{addr: daddress, data: dwritedata, be: dbyteenable};
  end

  // ---------------------------------------------------------------- load FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      // A store landing this cycle would be behind the load, so go drain it first.
      IDLE:    if (dread) state_nxt = (fifo_empty & ~dwrite) ? RD_REQ : DRAIN;
      DRAIN:   if (level_nxt == '0) state_nxt = RD_REQ;
      RD_REQ:  if (!avm_waitrequest) state_nxt = RD_WAIT;
      RD_WAIT: if (avm_readdatavalid) state_nxt = RD_DONE;
      RD_DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    avm_read       = (state == RD_REQ);
    avm_write      = wr_issue;
    avm_address    = '0;
    avm_writedata  = '0;
    avm_byteenable = '0;
    if (avm_read) begin
      avm_address    = daddress;
      avm_byteenable = dbyteenable;
    end else if (avm_write) begin
      avm_address    = head.addr;
      avm_writedata  = head.data;
      avm_byteenable = head.be;
    end
    dwaitrequest = dread & (state != RD_DONE);
  end

  // Read data is only taken while a load is outstanding; stray valids elsewhere
  // (including after a reset abort) leave the last loaded value in place.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                    dreaddata <= '0;
    else if ((state == RD_WAIT) && avm_readdatavalid) dreaddata <= avm_readdata;
  end

endmodule

// File: tb/tb_rv32i_dbus_bridge.sv
module tb_rv32i_dbus_bridge;
  localparam int LOG2D = 2;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [31:0]       daddress, dwritedata, dreaddata;
  logic              dwrite, dread, dwaitrequest;
  logic [3:0]        dbyteenable, avm_byteenable;
  logic [31:0]       avm_address, avm_writedata, avm_readdata;
  logic              avm_write, avm_read, avm_readdatavalid, avm_waitrequest;
  logic [LOG2D:0]    wbuf_level;
  logic              wbuf_overflow;

  always #5 clk = ~clk;

  rv32i_dbus_bridge #(.WBUF_LOG2_DEPTH(LOG2D)) dut (
    .clk(clk), .reset_n(reset_n),
    .daddress(daddress), .dwrite(dwrite), .dwritedata(dwritedata),
    .dbyteenable(dbyteenable), .dread(dread),
    .dreaddata(dreaddata), .dwaitrequest(dwaitrequest),
    .avm_address(avm_address), .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_byteenable(avm_byteenable), .avm_read(avm_read),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
    .avm_waitrequest(avm_waitrequest),
    .wbuf_level(wbuf_level), .wbuf_overflow(wbuf_overflow)
  );

  // Transaction-level model: a queue of posted stores, a word memory behind
  // the bus, and a read responder with a programmable latency.
  typedef struct { logic [31:0] a; logic [31:0] d; logic [3:0] be; } st_t;
  st_t         q[$];
  logic [31:0] wlog[$];
  logic [31:0] mem [logic [31:0]];
  bit          ovf, rdv_next, prev_rd_stall;
  logic [31:0] last_ld, rsp_data, prev_rd_addr;
  int          cnt, rsp_lat;
  int          tests, fails, n_wr, n_rd_cyc, n_stall, n_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_dreaddata"}, dreaddata, 32'd0);
    chk({tag, "_level"},     32'(wbuf_level), 32'd0);
    chk({tag, "_overflow"},  32'(wbuf_overflow), 32'd0);
    chk({tag, "_avm_read"},  32'(avm_read), 32'd0);
    chk({tag, "_avm_write"}, 32'(avm_write), 32'd0);
    chk({tag, "_avm_addr"},  avm_address, 32'd0);
    chk({tag, "_avm_wdata"}, avm_writedata, 32'd0);
    chk({tag, "_avm_be"},    32'(avm_byteenable), 32'd0);
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'd0;
  endfunction

  // Runs at the negedge: compare DUT outputs with the model, then advance the
  // model with this cycle's inputs and bus handshakes.
  task automatic cycle_check();
    bit          full;
    st_t         e;
    logic [31:0] w;
    if (!reset_n) begin
      chk_reset("inrst");
      q.delete(); ovf = 0; last_ld = 32'd0; cnt = 0; rdv_next = 0; prev_rd_stall = 0;
      return;
    end
    chk("level",    32'(wbuf_level), 32'(q.size()));
    chk("overflow", 32'(wbuf_overflow), 32'(ovf));
    chk("wr_vld",   32'(avm_write), 32'(q.size() != 0));
    chk("rd_wr_excl", 32'(avm_read & avm_write), 32'd0);
    if (avm_write && q.size() != 0) begin
      chk("wr_addr", avm_address, q[0].a);
      chk("wr_data", avm_writedata, q[0].d);
      chk("wr_be",   32'(avm_byteenable), 32'(q[0].be));
    end
    if (avm_read) begin
      chk("rd_order", 32'(q.size()), 32'd0);
      chk("rd_dread", 32'(dread), 32'd1);
      chk("rd_addr",  avm_address, daddress);
      chk("rd_be",    32'(avm_byteenable), 32'(dbyteenable));
    end
    if (prev_rd_stall) begin
      chk("rd_hold",      32'(avm_read), 32'd1);
      chk("rd_hold_addr", avm_address, prev_rd_addr);
    end
    if (!dread) chk("dwait_idle", 32'(dwaitrequest), 32'd0);
    if (dread && !dwaitrequest) begin
      chk("ld_data", dreaddata, rsp_data);
      last_ld = rsp_data;
      n_done++;
    end else begin
      chk("rdata_hold", dreaddata, last_ld);
    end
    // advance
    if (avm_read) n_rd_cyc++;
    if (dread && dwaitrequest) n_stall++;
    prev_rd_stall = avm_read && avm_waitrequest;
    prev_rd_addr  = avm_address;
    full = (q.size() == DEPTH);
    if (avm_write && !avm_waitrequest && q.size() != 0) begin
      e = q.pop_front();
      w = mem_rd(e.a);
      for (int b = 0; b < 4; b++) if (e.be[b]) w[b*8 +: 8] = e.d[b*8 +: 8];
      mem[e.a] = w;
      wlog.push_back(e.a);
      n_wr++;
    end
    if (dwrite) begin
      if (full) ovf = 1;
      else      q.push_back('{a: daddress, d: dwritedata, be: dbyteenable});
    end
    if (avm_read && !avm_waitrequest) begin
      cnt      = rsp_lat;
      rsp_data = mem_rd(avm_address);
    end else if (cnt > 0) begin
      cnt--;
    end
    rdv_next = (cnt == 1);
  endtask

  task automatic tick();
    @(negedge clk);
    cycle_check();
    @(posedge clk);
    #1;
    avm_readdatavalid = rdv_next;
    avm_readdata      = rdv_next ? rsp_data : 32'h5A5A_5A5A;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    daddress = a; dwritedata = d; dbyteenable = be; dwrite = 1'b1;
    tick();
    dwrite = 1'b0;
  endtask

  // Holds dread until the one-cycle dwaitrequest=0 window; waitrequest is high
  // for the first wait_n cycles counted from the cycle dread rises.
  task automatic do_load(input logic [31:0] a, input int wait_n, input int lat,
                         output logic [31:0] got, output int stalls,
                         output int rdc, output int lows);
    int s0, r0, d0;
    bit done;
    s0 = n_stall; r0 = n_rd_cyc; d0 = n_done; done = 0; got = 32'd0;
    rsp_lat = lat;
    daddress = a; dbyteenable = 4'hF; dread = 1'b1;
    for (int k = 0; k < 60 && !done; k++) begin
      avm_waitrequest = (k < wait_n);
      #1;
      if (!dwaitrequest) begin
        got  = dreaddata;
        done = 1;
      end
      tick();
    end
    dread = 1'b0; avm_waitrequest = 1'b0;
    chk("load_completed", 32'(done), 32'd1);
    stalls = n_stall - s0; rdc = n_rd_cyc - r0; lows = n_done - d0;
  endtask

  initial begin
    logic [31:0] got;
    int stalls, rdc, lows, w0;
    tests = 0; fails = 0; n_wr = 0; n_rd_cyc = 0; n_stall = 0; n_done = 0;
    ovf = 0; rdv_next = 0; prev_rd_stall = 0; cnt = 0; rsp_lat = 1;
    last_ld = 32'd0; rsp_data = 32'd0; prev_rd_addr = 32'd0;
    dwrite = 0; dread = 0; daddress = 0; dwritedata = 0; dbyteenable = 0;
    avm_readdata = 0; avm_readdatavalid = 0; avm_waitrequest = 0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1 chk_reset("por");
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // 1: single store, zero-wait bus
    w0 = n_wr;
    store(32'h100, 32'hDEADBEEF, 4'hF);
    chk("t1_level1", 32'(wbuf_level), 32'd1);
    chk("t1_write",  32'(avm_write), 32'd1);
    chk("t1_addr",   avm_address, 32'h100);
    chk("t1_data",   avm_writedata, 32'hDEADBEEF);
    chk("t1_be",     32'(avm_byteenable), 32'hF);
    tick();
    chk("t1_level0", 32'(wbuf_level), 32'd0);
    chk("t1_idle",   32'(avm_write), 32'd0);
    chk("t1_nwr",    32'(n_wr - w0), 32'd1);

    // 2: five stores into a stalled bus, fifth is dropped
    avm_waitrequest = 1'b1;
    w0 = n_wr;
    for (int i = 0; i < 5; i++) store(32'h10 * (i + 1), 32'h1111_0000 + i, 4'hF);
    chk("t2_level4",   32'(wbuf_level), 32'd4);
    chk("t2_overflow", 32'(wbuf_overflow), 32'd1);
    avm_waitrequest = 1'b0;
    repeat (6) tick();
    chk("t2_level0", 32'(wbuf_level), 32'd0);
    chk("t2_nwr",    32'(n_wr - w0), 32'd4);
    for (int i = 0; i < 4; i++)
      chk("t2_order", wlog[wlog.size() - 4 + i], 32'h10 * (i + 1));
    chk("t2_dropped", 32'(mem.exists(32'h50)), 32'd0);

    // 3: minimum-latency load
    mem[32'h200] = 32'hCAFEF00D;
    do_load(32'h200, 0, 1, got, stalls, rdc, lows);
    chk("t3_data",   got, 32'hCAFEF00D);
    chk("t3_stalls", 32'(stalls), 32'd3);
    chk("t3_rdcyc",  32'(rdc), 32'd1);
    chk("t3_lows",   32'(lows), 32'd1);
    tick();

    // 4: stores ahead of a load to the same address must land first
    avm_waitrequest = 1'b1;
    w0 = n_wr;
    store(32'h300, 32'hAAAA5555, 4'hF);
    store(32'h300, 32'h12345678, 4'hF);
    do_load(32'h300, 3, 1, got, stalls, rdc, lows);
    chk("t4_data",   got, 32'h12345678);
    chk("t4_nwr",    32'(n_wr - w0), 32'd2);
    chk("t4_stalls", 32'(stalls), 32'd7);
    tick();

    // 5: long command stall, slow data, then a stray valid while idle
    mem[32'h400] = 32'h0BADF00D;
    do_load(32'h400, 6, 4, got, stalls, rdc, lows);
    chk("t5_data",   got, 32'h0BADF00D);
    chk("t5_rdcyc",  32'(rdc), 32'd6);
    chk("t5_stalls", 32'(stalls), 32'd11);
    chk("t5_lows",   32'(lows), 32'd1);
    avm_readdata = 32'hFFFF_FFFF; avm_readdatavalid = 1'b1;
    tick(); tick();
    chk("t5_stray", dreaddata, 32'h0BADF00D);

    // 6: reset while waiting for read data
    mem[32'h500] = 32'h77778888;
    rsp_lat = 5;
    daddress = 32'h500; dbyteenable = 4'hF; dread = 1'b1;
    tick(); tick();
    reset_n = 1'b0; dread = 1'b0;
    #1 chk_reset("t6");
    tick(); tick();
    reset_n = 1'b1;
    tick();
    avm_readdata = 32'h77778888; avm_readdatavalid = 1'b1;
    tick(); tick();
    chk("t6_late_rdv", dreaddata, 32'd0);
    chk("t6_ovf_clr",  32'(wbuf_overflow), 32'd0);

    // 7: a store with no byte enables is still posted
    store(32'h600, 32'h99, 4'h0);
    chk("t7_write", 32'(avm_write), 32'd1);
    chk("t7_be",    32'(avm_byteenable), 32'd0);
    chk("t7_data",  avm_writedata, 32'h99);
    tick();
    chk("t7_level0", 32'(wbuf_level), 32'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
